debounce_multi: RTL



---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_channel.sv | 81 ++++++++
 rtl/debounce_multi.sv | 61 ++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
// Default timing and a width helper that never returns less than one bit.
package debounce_pkg;

   localparam int DEBOUNCE_DIVIDE = 65536;
   localparam int DEBOUNCE_STABLE = 1;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } chan_state_t;

   function automatic int clog2_min1(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) begin
         width++;
      end
      return width;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter, level and edge flops.
// The channel is PENDING whenever its counter is non-zero.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int   STABLE_COUNT = DEBOUNCE_STABLE,
   parameter logic RESET_LEVEL  = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic i_tick,
   input  logic i_in,
   output logic o_out,
   output logic o_rise,
   output logic o_fall
);

   localparam int               CNT_W = clog2_min1(STABLE_COUNT + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(STABLE_COUNT);

   logic             r_s1;
   logic             r_s2;
   logic             r_out;
   logic             r_rise;
   logic             r_fall;
   logic [CNT_W-1:0] r_cnt;

   chan_state_t      w_state;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_out_nxt;
   logic             w_rise_nxt;
   logic             w_fall_nxt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_s1   <= RESET_LEVEL;
         r_s2   <= RESET_LEVEL;
         r_out  <= RESET_LEVEL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_s1   <= i_in;
         r_s2   <= r_s1;
         r_out  <= w_out_nxt;
         r_rise <= w_rise_nxt;
         r_fall <= w_fall_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state    = (r_cnt == '0) ? ST_STABLE : ST_PENDING;
      w_cnt_inc  = r_cnt + CNT_W'(1);
      w_cnt_nxt  = r_cnt;
      w_out_nxt  = r_out;
      w_rise_nxt = 1'b0;
      w_fall_nxt = 1'b0;
      if (i_tick) begin
         if (r_s2 == r_out) begin
            // A sample matching the current level cancels any partial run.
            if (w_state == ST_PENDING) begin
               w_cnt_nxt = '0;
            end
         end else if (w_cnt_inc == LAST) begin
            w_out_nxt  = r_s2;
            w_cnt_nxt  = '0;
            w_rise_nxt = r_s2;
            w_fall_nxt = !r_s2;
         end else begin
            w_cnt_nxt = w_cnt_inc;
         end
      end
   end

   assign o_out  = r_out;
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: shared sample prescaler feeding independent channels.
// A tick fires on every enabled cycle where the prescaler sits at zero.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int   CHANNELS     = 4,
   parameter int   DIVIDE       = DEBOUNCE_DIVIDE,
   parameter int   STABLE_COUNT = DEBOUNCE_STABLE,
   parameter logic RESET_LEVEL  = 1'b0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                sample_tick
);

   localparam int               PRE_W   = clog2_min1(DIVIDE);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIVIDE - 1);

   logic [PRE_W-1:0] r_prescaler;
   logic             r_sample_tick;
   logic             w_tick;

   assign w_tick = enable && (r_prescaler == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_prescaler   <= '0;
         r_sample_tick <= 1'b0;
      end else begin
         r_sample_tick <= w_tick;
         if (enable) begin
            r_prescaler <= (r_prescaler == PRE_MAX) ? '0 : r_prescaler + PRE_W'(1);
         end
      end
   end

   assign sample_tick = r_sample_tick;

   generate
      for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
         debounce_channel #(
            .STABLE_COUNT (STABLE_COUNT),
            .RESET_LEVEL  (RESET_LEVEL)
         ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .i_tick (w_tick),
            .i_in   (in[g]),
            .o_out  (out[g]),
            .o_rise (rise[g]),
            .o_fall (fall[g])
         );
      end
   endgenerate

endmodule
